pipelined_adder: RTL and testbench

- Parametrised, pipelined, segmented carry-chain adder/subtractor for the ALU datapath.
- Splits a BITS-wide add into STAGES equal segments, one segment per clock, with carry registered between stages. Sustains one operation per cycle.
- Valid/ready handshake with full-pipeline stall; produces C/V/N/Z flags aligned with the result.

---
 rtl/pipelined_adder.sv | 187 ++++++++++++++++++
 tb/tb_pipelined_adder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Segmented carry-chain adder/subtractor: one SEG-bit slice per stage, carry registered between stages.
// Latency: STAGES cycles from accept to valid_o, plus one cycle per stall cycle.
// Backpressure: whole-pipe stall while valid_o is high and ready_i is low; ready_o = ~stall.
// Optional saturation is enabled by defining PIPELINED_ADDER_SAT_EN (adds port sat_i).
module pipelined_adder #(
    parameter int BITS   = 32,
    parameter int STAGES = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [BITS-1:0] bus_a_i,
    input  logic [BITS-1:0] bus_b_i,
    input  logic            carry_i,
    input  logic            sub_i,
`ifdef PIPELINED_ADDER_SAT_EN
    input  logic            sat_i,
`endif
    output logic            valid_o,
    input  logic            ready_i,
    output logic [BITS-1:0] bus_o,
    output logic            flag_c_o,
    output logic            flag_v_o,
    output logic            flag_n_o,
    output logic            flag_z_o
);

    localparam int SEG = BITS / STAGES;

    if ((STAGES < 1) || ((BITS % STAGES) != 0)) begin : g_bad_cfg
        $error("pipelined_adder: BITS must be a positive multiple of STAGES");
    end

    logic            stall;
    logic [BITS-1:0] b_eff;

    // Inputs of the final (top-segment) stage.
    logic            fin_vld;
    logic            fin_cin;
    logic [SEG-1:0]  fin_a;
    logic [SEG-1:0]  fin_b;
    logic [BITS-1:0] fin_lo;    // lower result segments, top SEG bits zero
`ifdef PIPELINED_ADDER_SAT_EN
    logic            fin_sat;
`endif

    logic [SEG:0]    fin_sum;
    logic [BITS-1:0] bus_d, bus_q;
    logic            flag_c_d, flag_v_d, flag_n_d, flag_z_d;
    logic            flag_c_q, flag_v_q, flag_n_q, flag_z_q;
    logic            out_vld_q;

    assign stall   = out_vld_q & ~ready_i;
    assign ready_o = ~stall;
    assign b_eff   = sub_i ? ~bus_b_i : bus_b_i;

    // Lower segment stages: each consumes the bottom SEG bits of the remaining operands,
    // appends its sum above the already-finished segments and forwards the carry.
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_seg
        localparam int LO   = k * SEG;
        localparam int DONE = LO + SEG;

        logic [BITS-LO-1:0]   a_in, b_in;
        logic                 cin, vld_in;
        logic [SEG:0]         sum;
        logic [DONE-1:0]      res_d;
        logic                 vld_q, cy_q;
        logic [BITS-DONE-1:0] a_q, b_q;
        logic [DONE-1:0]      res_q;
`ifdef PIPELINED_ADDER_SAT_EN
        logic                 sat_in, sat_q;
`endif

        if (k == 0) begin : g_first
            assign a_in   = bus_a_i;
            assign b_in   = b_eff;
            assign cin    = carry_i;
            assign vld_in = valid_i;
            assign res_d  = sum[SEG-1:0];
`ifdef PIPELINED_ADDER_SAT_EN
            assign sat_in = sat_i;
`endif
        end else begin : g_next
            assign a_in   = g_seg[k-1].a_q;
            assign b_in   = g_seg[k-1].b_q;
            assign cin    = g_seg[k-1].cy_q;
            assign vld_in = g_seg[k-1].vld_q;
            assign res_d  = {sum[SEG-1:0], g_seg[k-1].res_q};
`ifdef PIPELINED_ADDER_SAT_EN
            assign sat_in = g_seg[k-1].sat_q;
`endif
        end

        assign sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, cin};

        // Stage register: valid always advances when not stalled, data only with a valid op.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                res_q <= '0;
`ifdef PIPELINED_ADDER_SAT_EN
                sat_q <= 1'b0;
`endif
            end else if (!stall) begin
                vld_q <= vld_in;
                if (vld_in) begin
                    cy_q  <= sum[SEG];
                    a_q   <= a_in[BITS-LO-1:SEG];
                    b_q   <= b_in[BITS-LO-1:SEG];
                    res_q <= res_d;
`ifdef PIPELINED_ADDER_SAT_EN
                    sat_q <= sat_in;
`endif
                end
            end
        end
    end

    if (STAGES == 1) begin : g_fin_direct
        assign fin_vld = valid_i;
        assign fin_cin = carry_i;
        assign fin_a   = bus_a_i;
        assign fin_b   = b_eff;
        assign fin_lo  = '0;
`ifdef PIPELINED_ADDER_SAT_EN
        assign fin_sat = sat_i;
`endif
    end else begin : g_fin_piped
        assign fin_vld = g_seg[STAGES-2].vld_q;
        assign fin_cin = g_seg[STAGES-2].cy_q;
        assign fin_a   = g_seg[STAGES-2].a_q;
        assign fin_b   = g_seg[STAGES-2].b_q;
        assign fin_lo  = {{SEG{1'b0}}, g_seg[STAGES-2].res_q};
`ifdef PIPELINED_ADDER_SAT_EN
        assign fin_sat = g_seg[STAGES-2].sat_q;
`endif
    end

    // Top segment: final sum, flags from the MSB carries, optional clamp, then N/Z from the result.
    always_comb begin
        fin_sum  = {1'b0, fin_a} + {1'b0, fin_b} + {{SEG{1'b0}}, fin_cin};
        flag_c_d = fin_sum[SEG];
        // carry into the MSB is recovered from the MSB operand bits and sum bit
        flag_v_d = flag_c_d ^ (fin_a[SEG-1] ^ fin_b[SEG-1] ^ fin_sum[SEG-1]);
        bus_d    = fin_lo | (BITS'(fin_sum[SEG-1:0]) << (BITS - SEG));
`ifdef PIPELINED_ADDER_SAT_EN
        if (fin_sat && flag_v_d) begin
            bus_d = flag_c_d ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
        end
`endif
        flag_n_d = bus_d[BITS-1];
        flag_z_d = (bus_d == '0);
    end

    // Output register: holds result and flags through a stall and across bubbles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_vld_q <= 1'b0;
            bus_q     <= '0;
            flag_c_q  <= 1'b0;
            flag_v_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            flag_z_q  <= 1'b0;
        end else if (!stall) begin
            out_vld_q <= fin_vld;
            if (fin_vld) begin
                bus_q    <= bus_d;
                flag_c_q <= flag_c_d;
                flag_v_q <= flag_v_d;
                flag_n_q <= flag_n_d;
                flag_z_q <= flag_z_d;
            end
        end
    end

    assign valid_o  = out_vld_q;
    assign bus_o    = bus_q;
    assign flag_c_o = flag_c_q;
    assign flag_v_o = flag_v_q;
    assign flag_n_o = flag_n_q;
    assign flag_z_o = flag_z_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (BITS=32, STAGES=4).
// Reference model: plain 33-bit arithmetic, queue scoreboard with stall-aware due cycles.
// Saturation cases are exercised when PIPELINED_ADDER_SAT_EN is defined.
module tb_pipelined_adder;

    localparam int BITS   = 32;
    localparam int STAGES = 4;
    localparam int W      = 36;   // {C,V,N,Z,bus}

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            valid_i, ready_o, ready_i, valid_o;
    logic [BITS-1:0] bus_a_i, bus_b_i, bus_o;
    logic            carry_i, sub_i, sat_i;
    logic            flag_c_o, flag_v_o, flag_n_o, flag_z_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int n_out = 0;
    logic acc_flag;
    logic use_const = 1'b0;
    logic [W-1:0] const_exp;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    int           stl_q[$];

    pipelined_adder #(.BITS(BITS), .STAGES(STAGES)) dut (
`ifdef PIPELINED_ADDER_SAT_EN
        .sat_i    (sat_i),
`endif
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .bus_a_i  (bus_a_i),
        .bus_b_i  (bus_b_i),
        .carry_i  (carry_i),
        .sub_i    (sub_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .bus_o    (bus_o),
        .flag_c_o (flag_c_o),
        .flag_v_o (flag_v_o),
        .flag_n_o (flag_n_o),
        .flag_z_o (flag_z_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Arithmetic meaning of the operation, independent of segmentation.
    function automatic logic [W-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic cin, input logic sat);
        logic [31:0] bb, res;
        logic [32:0] full;
        logic        c, v;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, cin};
        res  = full[31:0];
        c    = full[32];
        v    = (a[31] == bb[31]) && (res[31] != a[31]);
        if (sat && v) res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return {c, v, res[31], (res == 32'd0), res};
    endfunction

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic cin, input logic sat, input logic vld);
        bus_a_i = a;
        bus_b_i = b;
        sub_i   = sub;
        carry_i = cin;
        sat_i   = sat;
        valid_i = vld;
    endtask

    // One clock: called just after a negedge with inputs set; checks outputs, updates model.
    task automatic tick();
        logic exp_vld;
        exp_vld = 1'b0;
        acc_flag = 1'b0;
        #1;
        if (exp_q.size() > 0) begin
            exp_vld = ((cyc - acc_q[0] - (stall_cnt - stl_q[0])) == STAGES);
        end
        check("valid_o", W'(valid_o), W'(exp_vld));
        check("ready_o", W'(ready_o), W'(!(exp_vld && !ready_i)));
        if (exp_vld && valid_o) begin
            check(ready_i ? "result" : "held",
                  {flag_c_o, flag_v_o, flag_n_o, flag_z_o, bus_o}, exp_q[0]);
        end
        if (exp_vld && ready_i) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            void'(stl_q.pop_front());
            n_out++;
        end
        if (valid_i && ready_o) begin
            exp_q.push_back(use_const ? const_exp
                                      : model(bus_a_i, bus_b_i, sub_i, carry_i, sat_i));
            acc_q.push_back(cyc);
            stl_q.push_back(stall_cnt);
            acc_flag = 1'b1;
        end
        if (exp_vld && !ready_i) stall_cnt++;
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic drain();
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int t = 0; t < 40 && exp_q.size() > 0; t++) tick();
        check("drain_empty", W'(exp_q.size()), W'(0));
        for (int t = 0; t < 2; t++) tick();
    endtask

    task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic sub,
                            input logic cin, input logic sat, input logic [W-1:0] exp);
        use_const = 1'b1;
        const_exp = exp;
        ready_i   = 1'b1;
        set_op(a, b, sub, cin, sat, 1'b1);
        tick();
        use_const = 1'b0;
        drain();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'hFFFF_FFFF;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int i, stall_left, base;
        rst_n_i = 1'b0;
        ready_i = 1'b0;
        set_op(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        check("rst_valid_o", W'(valid_o), W'(0));
        check("rst_ready_o", W'(ready_o), W'(1));
        check("rst_out", {flag_c_o, flag_v_o, flag_n_o, flag_z_o, bus_o}, W'(0));
        @(negedge clk_i);
        rst_n_i = 1'b1;
        ready_i = 1'b1;

        // Spec-derived constants {C,V,N,Z,bus}.
        directed(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 36'h0_0000_0100);
        directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 36'h9_0000_0000);
        directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 36'h6_8000_0000);
        directed(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 36'hD_0000_0000);
        directed(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 36'h2_FFFF_FFFE);
        directed(32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 36'h9_0000_0000);
`ifdef PIPELINED_ADDER_SAT_EN
        directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 36'h4_7FFF_FFFF);
        directed(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 36'hE_8000_0000);
        directed(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1, 36'h2_FFFF_FFFE);
`endif

        // Eight back-to-back ops, 3-cycle stall after the second result.
        i = 1;
        stall_left = 3;
        base = n_out;
        for (int t = 0; t < 60 && (i <= 8 || exp_q.size() > 0); t++) begin
            if (i <= 8) set_op(32'(i), 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
            else valid_i = 1'b0;
            ready_i = !((n_out - base) >= 2 && stall_left > 0);
            tick();
            if (acc_flag) i++;
            if (!ready_i) stall_left--;
        end
        check("stall_count", W'(n_out - base), W'(8));
        drain();

        // Reset with three ops in flight.
        ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_op($urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        valid_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_valid_o", W'(valid_o), W'(0));
        check("arst_out", {flag_c_o, flag_v_o, flag_n_o, flag_z_o, bus_o}, W'(0));
        exp_q.delete();
        acc_q.delete();
        stl_q.delete();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        directed(32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 36'h0_0000_0002);

        // Random traffic with random backpressure and bubbles.
        for (int t = 0; t < 600; t++) begin
            logic s;
            s = 1'b0;
`ifdef PIPELINED_ADDER_SAT_EN
            s = 1'($urandom_range(0, 1));
`endif
            set_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s,
                   ($urandom_range(0, 3) != 0));
            ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
